// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
package pipe_pkg;

    localparam int FWD_LANE_RS1 = 0;
    localparam int FWD_LANE_RS2 = 1;

    // Stage control layouts, each packed to the 16-bit control field.
    typedef struct packed {
        logic       rf_we;
        logic       dram_we;
        logic [1:0] br_type;
        logic       jump;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic [4:0] rd_addr;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       rf_we;
        logic       dram_we;
        logic [1:0] dram_size;
        logic [1:0] wb_sel;
        logic [4:0] rd_addr;
        logic [4:0] rsvd;
    } ex_mem_ctrl_t;

    function automatic int ops_width(input int num_ops, input int op_w);
        return num_ops * op_w;
    endfunction

    function automatic int lane_lo(input int lane, input int op_w);
        return lane * op_w;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake and payload bundle between two pipeline stages.
interface pipe_stage_buf_if import pipe_pkg::*; #(
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 96,
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 32
);
    localparam int OPS_W = ops_width(NUM_OPS, OP_W);

    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [CTRL_W-1:0]  in_ctrl_i;
    logic [DATA_W-1:0]  in_data_i;
    logic [OPS_W-1:0]   in_ops_i;
    logic [NUM_OPS-1:0] fwd_en_i;
    logic [OPS_W-1:0]   fwd_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [CTRL_W-1:0]  out_ctrl_o;
    logic [DATA_W-1:0]  out_data_o;
    logic [OPS_W-1:0]   out_ops_o;
    logic [1:0]         occ_o;

    modport master (
        output flush_i, in_valid_i, in_ctrl_i, in_data_i, in_ops_i,
               fwd_en_i, fwd_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, out_ops_o, occ_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_ctrl_i, in_data_i, in_ops_i,
               fwd_en_i, fwd_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, out_ops_o, occ_o
    );

endinterface

// File: rtl/pipe_stage_buf_fwd_mux.sv
// Per-lane operand override: a forwarded value replaces the register-file read.
module pipe_fwd_mux import pipe_pkg::*; #(
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 32
) (
    input  logic [ops_width(NUM_OPS, OP_W)-1:0] ops_i,
    input  logic [NUM_OPS-1:0]                  fwd_en_i,
    input  logic [ops_width(NUM_OPS, OP_W)-1:0] fwd_data_i,
    output logic [ops_width(NUM_OPS, OP_W)-1:0] ops_o
);

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_lane
        assign ops_o[lane_lo(k, OP_W) +: OP_W] = fwd_en_i[k] ? fwd_data_i[lane_lo(k, OP_W) +: OP_W]
                                                             : ops_i[lane_lo(k, OP_W) +: OP_W];
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with flush, capture-time forwarding and
// an optional skid entry that keeps in_ready_o off the downstream ready path.
module pipe_stage_buf import pipe_pkg::*; #(
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 96,
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 32,
    parameter int SKID    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_buf_if.slave  bus
);

    localparam int OPS_W = ops_width(NUM_OPS, OP_W);

    logic               main_valid_q, main_valid_d;
    logic [CTRL_W-1:0]  main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q,  main_data_d;
    logic [OPS_W-1:0]   main_ops_q,   main_ops_d;
    logic               skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0]  skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q,  skid_data_d;
    logic [OPS_W-1:0]   skid_ops_q,   skid_ops_d;

    logic               in_ready;
    logic               accept;
    logic               drain;
    logic [OPS_W-1:0]   cap_ops;

    pipe_fwd_mux #(
        .NUM_OPS (NUM_OPS),
        .OP_W    (OP_W)
    ) u_fwd_mux (
        .ops_i      (bus.in_ops_i),
        .fwd_en_i   (bus.fwd_en_i),
        .fwd_data_i (bus.fwd_data_i),
        .ops_o      (cap_ops)
    );

    // rst_n gating keeps the stage from accepting while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = rst_n & ~skid_valid_q;
        end else begin
            in_ready = rst_n & (~main_valid_q | bus.out_ready_i);
        end
    end

    assign accept = bus.in_valid_i & in_ready;
    assign drain  = main_valid_q & bus.out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_ops_d   = main_ops_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_ops_d   = skid_ops_q;

        if (bus.flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (drain && skid_valid_q) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            main_ops_d   = skid_ops_q;
            skid_valid_d = 1'b0;
        end else if (accept && main_valid_q && !drain) begin
            // Only reachable with a skid entry; SKID=0 never accepts into a full stage.
            skid_valid_d = 1'b1;
            skid_ctrl_d  = bus.in_ctrl_i;
            skid_data_d  = bus.in_data_i;
            skid_ops_d   = cap_ops;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = bus.in_ctrl_i;
            main_data_d  = bus.in_data_i;
            main_ops_d   = cap_ops;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_ops_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_ops_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_ops_q   <= main_ops_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_ops_q   <= skid_ops_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = main_valid_q;
    assign bus.out_ctrl_o  = main_ctrl_q;
    assign bus.out_data_o  = main_data_q;
    assign bus.out_ops_o   = main_ops_q;
    assign bus.occ_o       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one instance with the skid entry, one without.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW  = 16;
    localparam int DW  = 96;
    localparam int NO  = 2;
    localparam int OW  = 32;
    localparam int OPW = NO * OW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .OP_W(OW)) if1 ();
    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .OP_W(OW)) if0 ();

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .OP_W(OW), .SKID(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .OP_W(OW), .SKID(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    typedef struct {
        logic [CW-1:0]  ctrl;
        logic [DW-1:0]  data;
        logic [OPW-1:0] ops;
    } ent_t;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [CW-1:0] ctrl;
        logic          e_v;
        logic [1:0]    e_occ;
        logic          e_rdy;
        logic [CW-1:0] e_ctrl;
    } vec_t;

    ent_t          q0[$];
    ent_t          q1[$];
    logic [CW-1:0] hold_ctrl[2];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic iv, input logic ordy, input logic fl,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [OPW-1:0] o,
                       input logic [NO-1:0] fe, input logic [OPW-1:0] fd);
        if (k == 1) begin
            if1.in_valid_i = iv;  if1.out_ready_i = ordy; if1.flush_i = fl;
            if1.in_ctrl_i  = c;   if1.in_data_i   = d;    if1.in_ops_i = o;
            if1.fwd_en_i   = fe;  if1.fwd_data_i  = fd;
        end else begin
            if0.in_valid_i = iv;  if0.out_ready_i = ordy; if0.flush_i = fl;
            if0.in_ctrl_i  = c;   if0.in_data_i   = d;    if0.in_ops_i = o;
            if0.fwd_en_i   = fe;  if0.fwd_data_i  = fd;
        end
    endtask

    // Capture value: each lane takes the forwarded word when its enable is set.
    function automatic logic [OPW-1:0] fwd_model(input logic [OPW-1:0] ops, input logic [NO-1:0] fe,
                                                  input logic [OPW-1:0] fd);
        logic [OPW-1:0] r;
        r = ops;
        for (int l = 0; l < NO; l++) begin
            if (fe[l]) r[l*OW +: OW] = fd[l*OW +: OW];
        end
        return r;
    endfunction

    // FIFO model: capacity 2 with skid, 1 without; ready rules from the stage's contract.
    task automatic model_cycle(input int k, input logic iv, input logic ordy, input logic fl, input ent_t cap);
        ent_t           q[$];
        ent_t           popped;
        logic           v, rdy, e_rdy;
        logic [1:0]     occ;
        logic [CW-1:0]  c;
        logic [DW-1:0]  d;
        logic [OPW-1:0] o;
        int             sz;
        if (k == 1) begin
            q = q1;
            v = if1.out_valid_o; rdy = if1.in_ready_o; occ = if1.occ_o;
            c = if1.out_ctrl_o;  d = if1.out_data_o;   o = if1.out_ops_o;
        end else begin
            q = q0;
            v = if0.out_valid_o; rdy = if0.in_ready_o; occ = if0.occ_o;
            c = if0.out_ctrl_o;  d = if0.out_data_o;   o = if0.out_ops_o;
        end
        sz = q.size();
        e_rdy = (k == 1) ? (sz < 2) : (sz == 0 || ordy);
        chk($sformatf("rnd%0d valid", k), v, sz != 0);
        chk($sformatf("rnd%0d occ", k), occ, sz);
        chk($sformatf("rnd%0d ready", k), rdy, e_rdy);
        if (sz != 0) begin
            chk($sformatf("rnd%0d ctrl", k), c, q[0].ctrl);
            chk($sformatf("rnd%0d data", k), d, q[0].data);
            chk($sformatf("rnd%0d ops", k), o, q[0].ops);
        end else begin
            chk($sformatf("rnd%0d idle ctrl", k), c, hold_ctrl[k]);
        end
        if (fl) begin
            q.delete();
            hold_ctrl[k] = '0;
        end else begin
            if (sz != 0 && ordy) begin
                popped = q.pop_front();
                hold_ctrl[k] = popped.ctrl;
            end
            if (iv && e_rdy) q.push_back(cap);
        end
        if (k == 1) q1 = q; else q0 = q;
    endtask

    vec_t tbl[10];

    initial begin
        logic [NO-1:0]  fe;
        logic [OPW-1:0] held_ops;
        ent_t           cap;
        logic           iv, ordy, fl;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h00A5, 1'b1, 2'd1, 1'b1, 16'h00A5};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h000B, 1'b1, 2'd2, 1'b0, 16'h00A5};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h000C, 1'b1, 2'd2, 1'b0, 16'h00A5};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h000C, 1'b1, 2'd1, 1'b1, 16'h000B};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h000C, 1'b1, 2'd1, 1'b1, 16'h000C};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'h000C};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h001D, 1'b1, 2'd1, 1'b1, 16'h001D};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h001E, 1'b1, 2'd2, 1'b0, 16'h001D};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 16'h001F, 1'b0, 2'd0, 1'b1, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'h0000};

        // Reset held for two cycles with garbage offered upstream.
        rst_n = 1'b0;
        drv(1, 1'b1, 1'b1, 1'b0, '1, '1, '1, '1, '1);
        drv(0, 1'b1, 1'b1, 1'b0, '1, '1, '1, '1, '1);
        tick();
        tick();
        chk("rst valid1", if1.out_valid_o, 1'b0);
        chk("rst occ1", if1.occ_o, 2'd0);
        chk("rst ready1", if1.in_ready_o, 1'b0);
        chk("rst ctrl1", if1.out_ctrl_o, '0);
        chk("rst data1", if1.out_data_o, '0);
        chk("rst ops1", if1.out_ops_o, '0);
        chk("rst valid0", if0.out_valid_o, 1'b0);
        chk("rst ready0", if0.in_ready_o, 1'b0);

        rst_n = 1'b1;
        drv(1, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
        drv(0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
        #1;
        chk("rel ready1", if1.in_ready_o, 1'b1);
        chk("rel ready0", if0.in_ready_o, 1'b1);

        // Single pass.
        drv(1, 1'b1, 1'b1, 1'b0, 16'h00A5, 96'h100, {32'h22, 32'h11}, '0, '0);
        tick();
        chk("pass valid", if1.out_valid_o, 1'b1);
        chk("pass ctrl", if1.out_ctrl_o, 16'h00A5);
        chk("pass data", if1.out_data_o, 96'h100);
        chk("pass ops", if1.out_ops_o, {32'h22, 32'h11});
        chk("pass occ", if1.occ_o, 2'd1);

        // Forward override on the rs2 lane only.
        fe = '0;
        fe[FWD_LANE_RS2] = 1'b1;
        drv(1, 1'b1, 1'b1, 1'b0, 16'h0077, 96'h104, {32'h22, 32'h11}, fe, {32'hDEAD, 32'hBEEF});
        tick();
        chk("fwd ops", if1.out_ops_o, {32'hDEAD, 32'h11});
        chk("fwd occ", if1.occ_o, 2'd1);
        held_ops = {32'hDEAD, 32'h11};
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0, {$urandom, $urandom}, 2'b11, {$urandom, $urandom});
        tick();
        tick();
        chk("fwd hold ops", if1.out_ops_o, held_ops);
        chk("fwd hold ctrl", if1.out_ctrl_o, 16'h0077);
        chk("fwd hold valid", if1.out_valid_o, 1'b1);
        drv(1, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
        tick();
        chk("fwd drain valid", if1.out_valid_o, 1'b0);

        // Backpressure, ordering and flush, one row per cycle.
        for (int i = 0; i < 10; i++) begin
            drv(1, tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].ctrl, {80'h0, tbl[i].ctrl},
                {16'h0, tbl[i].ctrl, 16'h0, tbl[i].ctrl}, '0, '0);
            tick();
            chk($sformatf("tbl%0d valid", i), if1.out_valid_o, tbl[i].e_v);
            chk($sformatf("tbl%0d occ", i), if1.occ_o, tbl[i].e_occ);
            chk($sformatf("tbl%0d ready", i), if1.in_ready_o, tbl[i].e_rdy);
            chk($sformatf("tbl%0d ctrl", i), if1.out_ctrl_o, tbl[i].e_ctrl);
        end
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);

        // SKID=0: back-to-back throughput and combinational ready.
        for (int i = 0; i < 8; i++) begin
            drv(0, 1'b1, 1'b1, 1'b0, CW'(i + 1), DW'(i + 16), OPW'(i + 32), '0, '0);
            tick();
            chk($sformatf("thru%0d valid", i), if0.out_valid_o, 1'b1);
            chk($sformatf("thru%0d ctrl", i), if0.out_ctrl_o, CW'(i + 1));
            chk($sformatf("thru%0d occ", i), if0.occ_o, 2'd1);
        end
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        #1;
        chk("s0 ready low", if0.in_ready_o, 1'b0);
        if0.out_ready_i = 1'b1;
        #1;
        chk("s0 ready high", if0.in_ready_o, 1'b1);
        tick();
        chk("s0 drained", if0.out_valid_o, 1'b0);

        // Reset with two entries held.
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0031, 96'h31, 64'h31, '0, '0);
        tick();
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0032, 96'h32, 64'h32, '0, '0);
        tick();
        chk("mid occ", if1.occ_o, 2'd2);
        rst_n = 1'b0;
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0033, 96'h33, 64'h33, '0, '0);
        tick();
        chk("mid rst valid", if1.out_valid_o, 1'b0);
        chk("mid rst occ", if1.occ_o, 2'd0);
        chk("mid rst ctrl", if1.out_ctrl_o, '0);
        chk("mid rst data", if1.out_data_o, '0);
        chk("mid rst ops", if1.out_ops_o, '0);
        chk("mid rst ready", if1.in_ready_o, 1'b0);
        rst_n = 1'b1;
        drv(1, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
        drv(0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post rst%0d valid", i), if1.out_valid_o, 1'b0);
        end

        // Random traffic against the FIFO model on both instances.
        q0.delete();
        q1.delete();
        hold_ctrl[0] = '0;
        hold_ctrl[1] = '0;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            cap.ctrl = CW'($urandom);
            cap.data = {$urandom, $urandom, $urandom};
            fe = NO'($urandom);
            begin
                logic [OPW-1:0] ops, fd;
                ops = {$urandom, $urandom};
                fd  = {$urandom, $urandom};
                cap.ops = fwd_model(ops, fe, fd);
                drv(1, iv, ordy, fl, cap.ctrl, cap.data, ops, fe, fd);
                drv(0, iv, ordy, fl, cap.ctrl, cap.data, ops, fe, fd);
            end
            #1;
            model_cycle(1, iv, ordy, fl, cap);
            model_cycle(0, iv, ordy, fl, cap);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline register for the RV core, replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM).
- Carries a control field, which is zeroed on flush, and a data payload, which is not cleared on flush.
- Carries NUM_OPS operand lanes with capture-time forwarding override.
- Uses a valid/ready handshake, so stalls are backpressure instead of ad-hoc hold logic.
- Optional 2-entry skid buffer makes in_ready_o purely registered, breaking the combinational ready chain between stages.

Parameters:
CTRL_W, 16, width of control field (rf_we, dram_we, branch/jump type, wr addr...); zeroed on flush/reset
DATA_W, 96, width of payload (pc, pc4, imm...); not cleared on flush
NUM_OPS, 2, number of operand lanes with forwarding override
OP_W, 32, width of each operand lane
SKID, 1, 0 = single register with combinational ready; 1 = main + skid register, registered ready

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
flush_i  in  1  kill all held and incoming entries
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept
in_ctrl_i  in  CTRL_W  upstream control
in_data_i  in  DATA_W  upstream payload
in_ops_i  in  NUM_OPS*OP_W  register-file operands, lane k at [k*OP_W +: OP_W]
fwd_en_i  in  NUM_OPS  per-lane forward select
fwd_data_i  in  NUM_OPS*OP_W  per-lane forwarded value
out_valid_o  out  1  downstream entry valid
out_ready_i  in  1  downstream accepts
out_ctrl_o  out  CTRL_W  held control
out_data_o  out  DATA_W  held payload
out_ops_o  out  NUM_OPS*OP_W  held operands
occ_o  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset: one clock, one synchronous reset rst_n, active-low. Reset is sampled only at the clk edge.
  - Values on reset: out_valid_o=0, skid_valid=0, out_ctrl_o=0, out_data_o=0, out_ops_o=0, occ_o=0, skid registers=0.
  - in_ready_o=0 while rst_n=0; it is 1 in the first cycle after reset release.
- Forward mux: combinational, per lane. op_k = fwd_en_i[k] ? fwd_data_i lane k : in_ops_i lane k.
  - Applied only at capture. Held entries are never re-forwarded.
- Transfers:
  - accept = in_valid_i & in_ready_o
  - drain = out_valid_o & out_ready_i
  - Latency is 1 cycle from accept to out_valid_o when the stage is empty.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - On accept, main <= {ctrl, data, op}; out_valid_o <= 1.
  - On drain without accept, out_valid_o <= 0 (ctrl/data/ops retained).
- SKID=1:
  - in_ready_o = ~skid_valid (registered only).
  - Accept with main empty or draining: main <= input.
  - Accept with main valid and not draining: skid <= input, skid_valid <= 1.
  - Drain with skid_valid: main <= skid, skid_valid <= 0, out_valid_o stays 1.
  - Drain with skid empty and no accept: out_valid_o <= 0.
  - Ordering is strictly FIFO; at most 2 entries.
- Flush (priority over accept/drain, below reset):
  - Next cycle out_valid_o=0, skid_valid=0, out_ctrl_o=0, skid ctrl=0.
  - The incoming entry in the same cycle is dropped.
  - Data/ops registers keep their old values (don't-care).
  - in_ready_o follows its normal rule; with SKID=1 it is 1 the cycle after flush.
- A downstream drain in the flush cycle still completes downstream. The stage does not retract out_valid_o combinationally.
- out_valid_o is never deasserted without drain, flush or reset. Outputs are stable while out_valid_o & ~out_ready_i.
- Invariants:
  - occ_o = out_valid_o + skid_valid.
  - skid_valid implies out_valid_o.
- in_valid_i with ~in_ready_o: input ignored; upstream must hold.

Decomposition:
- Package pipe_pkg:
  - typedefs for per-stage control structs (id_ex_ctrl_t etc., packed to CTRL_W)
  - constant FWD_LANE_RS1=0, FWD_LANE_RS2=1
  - localparam helper for the OP_W*NUM_OPS slice
- Sub-module pipe_fwd_mux: a generate loop over lanes implementing the capture-time override, reused by the EX-stage bypass.

Test Plan:
- Reset and single pass, SKID=1: hold rst_n=0 for 2 cycles → all outputs 0, in_ready_o=0. Release, then send ctrl=16'h00A5, data=pc 0x100, ops {0x11, 0x22}, out_ready_i=1 → next cycle out_valid_o=1 with those values, occ_o=1.
- Forwarding: in_ops_i={0x11, 0x22}, fwd_en_i=2'b10, fwd_data_i lane1=0xDEAD → out_ops_o={0x11, 0xDEAD}. After fwd_en_i changes while the entry is held, out_ops_o is unchanged.
- Backpressure, SKID=1: out_ready_i=0, send A then B → occ_o=2, in_ready_o=0, C stalls. Raise out_ready_i → A, B, C emerge in order with no loss or duplication.
- Flush, SKID=1: with 2 entries held, flush_i=1 together with in_valid_i=1 (entry D) → next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, in_ready_o=1; D never appears at the output.
- SKID=0 throughput: in_valid_i and out_ready_i both held 1 for 8 back-to-back entries → one entry per cycle. in_ready_o follows out_ready_i combinationally when full.
- Reset mid-operation: occ_o=2, then pull rst_n=0 for 1 cycle → next cycle everything is 0. The held entries never appear at the output.
